div_ctrl: RTL and testbench

- Multi-cycle controller that sequences the iterative DIV/DIVU operation for the execute stage.
- Accepts a start request when the ALU decode selects DIV_CONTROL or DIVU_CONTROL.
- Holds the pipeline via a stall signal while it runs a radix-2 shift-subtract loop.
- Returns {remainder, quotient} for the HI/LO write. Sits beside the ALU in EX; the hazard unit consumes stall_o.

---
 rtl/div_ctrl_pkg.sv | 16 +
 rtl/div_step.sv | 33 +++
 rtl/div_ctrl.sv | 178 +++++++++++++++++
 tb/tb_div_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the iterative DIV/DIVU controller beside the EX-stage ALU.
package div_ctrl_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_ZERO = 2'b01,
    DIV_ON   = 2'b10,
    DIV_END  = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring shift-subtract iteration; the quotient bit enters the
// low end of the dividend shift register.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] partial_rem,
  input  logic [WIDTH-1:0] dividend_shift,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] dvd_next,
  output logic             q_bit
);

  // The shifted remainder needs one extra bit; the difference always fits in WIDTH bits.
  logic [WIDTH:0]   trial_s;
  logic [WIDTH-1:0] diff_s;

  assign trial_s  = {partial_rem, dividend_shift[WIDTH-1]};
  assign diff_s   = trial_s[WIDTH-1:0] - divisor;
  assign q_bit    = (trial_s >= {1'b0, divisor});
  assign dvd_next = {dividend_shift[WIDTH-2:0], q_bit};

  // Restore or keep the subtracted remainder
  always_comb begin
    rem_next = trial_s[WIDTH-1:0];
    if (q_bit) begin
      rem_next = diff_s;
    end else begin
      rem_next = trial_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer; result_o = {HI = remainder, LO = quotient}.
// Optional DIV_FAST_PATH_EN: skip the loop when |dividend| < |divisor|.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stall_o
);

  div_state_e         state_r, state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   rem_r, dvd_r, dvs_r;
  logic               neg_q_r, neg_r_r;
  logic [WIDTH-1:0]   op1_mag_s, op2_mag_s;
  logic               zero_s, fast_s, last_s;
  logic [WIDTH-1:0]   rem_step_s, dvd_step_s;
  logic               qbit_s;
  logic [WIDTH-1:0]   quot_fix_s, rem_fix_s;
  logic               ready_s;
  logic [2*WIDTH-1:0] result_s;

  assign stall_o = start_i & ~ready_o & ~annul_i;
  assign zero_s  = (opdata2_i == {WIDTH{1'b0}});
  assign last_s  = (cnt_r == CNT_W'(WIDTH - 1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .partial_rem    (rem_r),
    .dividend_shift (dvd_r),
    .divisor        (dvs_r),
    .rem_next       (rem_step_s),
    .dvd_next       (dvd_step_s),
    .q_bit          (qbit_s)
  );

  // Operand magnitudes at accept and the short-path decision
  always_comb begin
    op1_mag_s = opdata1_i;
    op2_mag_s = opdata2_i;
    if (signed_i && opdata1_i[WIDTH-1]) begin
      op1_mag_s = {WIDTH{1'b0}} - opdata1_i;
    end else begin
      op1_mag_s = opdata1_i;
    end
    if (signed_i && opdata2_i[WIDTH-1]) begin
      op2_mag_s = {WIDTH{1'b0}} - opdata2_i;
    end else begin
      op2_mag_s = opdata2_i;
    end
`ifdef DIV_FAST_PATH_EN
    fast_s = (op1_mag_s < op2_mag_s);
`else
    fast_s = 1'b0;
`endif
  end

  // Sign fix on the final iteration's outputs (modulo 2^WIDTH)
  always_comb begin
    quot_fix_s = dvd_step_s;
    rem_fix_s  = rem_step_s;
    if (neg_q_r) begin
      quot_fix_s = {WIDTH{1'b0}} - dvd_step_s;
    end else begin
      quot_fix_s = dvd_step_s;
    end
    if (neg_r_r) begin
      rem_fix_s = {WIDTH{1'b0}} - rem_step_s;
    end else begin
      rem_fix_s = rem_step_s;
    end
  end

  // Next state and next registered outputs; annul overrides every state
  always_comb begin
    state_s  = state_r;
    ready_s  = DIV_RESULT_NOT_READY;
    result_s = result_o;
    if (annul_i) begin
      state_s = DIV_IDLE;
    end else begin
      case (state_r)
        DIV_IDLE: begin
          if (start_i) begin
            if (zero_s || fast_s) begin
              state_s = DIV_ZERO;
            end else begin
              state_s = DIV_ON;
            end
          end else begin
            state_s = DIV_IDLE;
          end
        end
        DIV_ZERO: begin
          // Divide-by-zero and fast path both preload the final result at accept.
          state_s  = DIV_END;
          ready_s  = DIV_RESULT_READY;
          result_s = {rem_r, dvd_r};
        end
        DIV_ON: begin
          if (last_s) begin
            state_s  = DIV_END;
            ready_s  = DIV_RESULT_READY;
            result_s = {rem_fix_s, quot_fix_s};
          end else begin
            state_s = DIV_ON;
          end
        end
        DIV_END: state_s = DIV_IDLE;
        default: state_s = DIV_IDLE;
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= DIV_IDLE;
      ready_o  <= DIV_RESULT_NOT_READY;
      result_o <= {(2*WIDTH){1'b0}};
    end else begin
      state_r  <= state_s;
      ready_o  <= ready_s;
      result_o <= result_s;
    end
  end

  // Datapath: operand capture at accept, one iteration per ON cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= {CNT_W{1'b0}};
      rem_r   <= {WIDTH{1'b0}};
      dvd_r   <= {WIDTH{1'b0}};
      dvs_r   <= {WIDTH{1'b0}};
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else if (!annul_i) begin
      case (state_r)
        DIV_IDLE: begin
          if (start_i) begin
            cnt_r   <= {CNT_W{1'b0}};
            dvs_r   <= op2_mag_s;
            neg_q_r <= signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_r_r <= signed_i & opdata1_i[WIDTH-1];
            if (zero_s) begin
              rem_r <= opdata1_i;
              dvd_r <= {WIDTH{1'b1}};
            end else if (fast_s) begin
              rem_r <= opdata1_i;
              dvd_r <= {WIDTH{1'b0}};
            end else begin
              rem_r <= {WIDTH{1'b0}};
              dvd_r <= op1_mag_s;
            end
          end
        end
        DIV_ON: begin
          rem_r <= rem_step_s;
          dvd_r <= dvd_step_s;
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed cases plus random operands against
// an integer-arithmetic reference model.
module tb_div_ctrl;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst, start_i, signed_i, annul_i;
  logic [W-1:0]   opdata1_i, opdata2_i;
  logic [2*W-1:0] result_o;
  logic           ready_o, stall_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .signed_i  (signed_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .annul_i   (annul_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .stall_o   (stall_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: truncating integer division; remainder follows the dividend's sign.
  function automatic logic [2*W-1:0] ref_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    if (b == '0) return {a, {W{1'b1}}};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    q = sa / sb;
    r = sa % sb;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  function automatic int ref_lat(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    longint ma, mb;
    if (b == '0) return 2;
    ma = sgn ? longint'($signed(a)) : longint'(a);
    mb = sgn ? longint'($signed(b)) : longint'(b);
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
`ifdef DIV_FAST_PATH_EN
    if (ma < mb) return 2;
`endif
    return W + 1;
  endfunction

  task automatic run_op(input string tag, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] exp_res;
    int exp_lat, cyc, stall_bad;
    exp_res = ref_div(sgn, a, b);
    exp_lat = ref_lat(sgn, a, b);
    @(negedge clk);
    start_i = 1'b1; signed_i = sgn; opdata1_i = a; opdata2_i = b;
    #1;
    chk({tag, "_stall_c0"}, 64'(stall_o), 64'd1);
    cyc = 0; stall_bad = 0;
    while (!ready_o && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (!ready_o && !stall_o) stall_bad++;
    end
    chk({tag, "_ready_seen"}, 64'(ready_o), 64'd1);
    chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_stall_held"}, 64'(stall_bad), 64'd0);
    chk({tag, "_stall_at_ready"}, 64'(stall_o), 64'd0);
    chk({tag, "_result"}, result_o, exp_res);
    start_i = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_ready_pulse"}, 64'(ready_o), 64'd0);
    chk({tag, "_result_hold"}, result_o, exp_res);
  endtask

  initial begin
    logic [2*W-1:0] saved;
    int seen;
    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_result", result_o, 64'd0);
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_stall", 64'(stall_o), 64'd0);
    rst = 1'b0;

    run_op("u100_7", 1'b0, 32'd100, 32'd7);
    run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
    run_op("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("u_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divzero", 1'b0, 32'd5, 32'd0);
    run_op("s_divzero", 1'b1, 32'hFFFF_FFF0, 32'd0);
    run_op("u3_10", 1'b0, 32'd3, 32'd10);
    run_op("s_m3_10", 1'b1, 32'hFFFF_FFFD, 32'd10);

    // Annul at cycle 10 of 20 / 3: no ready, result unchanged
    saved = result_o;
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd20; opdata2_i = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    annul_i = 1'b1;
    #1;
    chk("annul_stall", 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    annul_i = 1'b0; start_i = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o) seen++;
    end
    chk("annul_no_ready", 64'(seen), 64'd0);
    chk("annul_result_hold", result_o, saved);
    run_op("restart_20_3", 1'b0, 32'd20, 32'd3);
    chk("restart_value", result_o, {32'd2, 32'd6});

    // Reset at cycle 15 mid-ON
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_result", result_o, 64'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o) seen++;
    end
    chk("rst_mid_no_ready", 64'(seen), 64'd0);
    chk("rst_mid_result_hold", result_o, 64'd0);

    // Random operands, biased towards zero divisors and small quotients
    for (int i = 0; i < 24; i++) begin
      logic sgn;
      logic [W-1:0] a, b;
      int mode;
      sgn  = 1'($urandom_range(0, 1));
      mode = int'($urandom_range(0, 3));
      a = $urandom;
      case (mode)
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: b = $urandom;
        default: begin
          a = W'($urandom_range(0, 9));
          b = W'($urandom_range(10, 99));
          if (sgn && $urandom_range(0, 1) == 1) b = '0 - b;
        end
      endcase
      run_op($sformatf("rand%0d", i), sgn, a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
